uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 172 +++++++++++++++++
 tb/tb_uart_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// uart_loader: receives a length-prefixed little-endian frame of 16-bit words
// from a byte stream and writes each word to memory at 0-based addresses.
// Optional feature macro: UART_LOADER_CHECKSUM_EN. When it is defined, the
// frame carries a trailing 16-bit sum of the payload words, and a mismatch
// aborts the frame.
module uart_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned MAX_WORDS      = 1024
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        byte_ready,
  input  logic [7:0]  byte_in,
  input  logic        clear,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
`ifdef UART_LOADER_CHECKSUM_EN
    S_CSUM_LO,
    S_CSUM_HI,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  // State entered once the payload is complete.
`ifdef UART_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM_LO;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t            state_q, state_d;
  logic              ready_q;
  logic              armed_q;
  logic [7:0]        lo_q;
  logic [15:0]       len_q;
  logic [15:0]       idx_q;
  logic [TO_W-1:0]   to_q;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [15:0]       csum_q;
`endif

  logic              byte_acc_c;
  logic              in_frame_c;
  logic              timeout_hit_c;
  logic              last_word_c;
  logic              take_lo_c;
  logic              busy_next_c;
  logic              wr_c;
  logic [15:0]       word_c;

  // Byte strobe: rising edge of byte_ready, only once the edge register holds
  // a value sampled after reset, so a level already high at reset release is
  // ignored.
  assign byte_acc_c    = byte_ready & ~ready_q & armed_q;
  assign word_c        = {byte_in, lo_q};
  assign in_frame_c    = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign timeout_hit_c = in_frame_c && !byte_acc_c && (to_q == TO_LAST);
  assign last_word_c   = ((idx_q + 16'd1) == len_q);
  assign busy_next_c   = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERROR);
`ifdef UART_LOADER_CHECKSUM_EN
  assign take_lo_c = byte_acc_c && !clear &&
                     (state_q == S_IDLE || state_q == S_DATA_LO || state_q == S_CSUM_LO);
`else
  assign take_lo_c = byte_acc_c && !clear &&
                     (state_q == S_IDLE || state_q == S_DATA_LO);
`endif

  // State register.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and write request; clear beats timeout beats bytes.
  always_comb begin
    state_d = state_q;
    wr_c    = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
    end else if (timeout_hit_c) begin
      state_d = S_ERROR;
    end else if (byte_acc_c) begin
      case (state_q)
        S_IDLE:    state_d = S_LEN_HI;
        S_LEN_HI: begin
          if (word_c > MAX_LEN)     state_d = S_ERROR;
          else if (word_c == 16'd0) state_d = S_TAIL;
          else                      state_d = S_DATA_LO;
        end
        S_DATA_LO: state_d = S_DATA_HI;
        S_DATA_HI: begin
          wr_c    = 1'b1;
          state_d = last_word_c ? S_TAIL : S_DATA_LO;
        end
`ifdef UART_LOADER_CHECKSUM_EN
        S_CSUM_LO: state_d = S_CSUM_HI;
        S_CSUM_HI: state_d = (word_c == csum_q) ? S_DONE : S_ERROR;
`endif
        default:   state_d = state_q;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      armed_q  <= 1'b0;
      lo_q     <= 8'd0;
      len_q    <= 16'd0;
      idx_q    <= 16'd0;
      to_q     <= '0;
      mem_we   <= 1'b0;
      mem_addr <= 16'd0;
      mem_data <= 16'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q   <= 16'd0;
`endif
    end else begin
      ready_q <= byte_ready;
      armed_q <= 1'b1;
      mem_we  <= wr_c;
      busy    <= busy_next_c;
      done    <= (state_d == S_DONE);
      error   <= (state_d == S_ERROR);
      if (wr_c) begin
        mem_addr <= idx_q;
        mem_data <= word_c;
      end
      if (clear) begin
        lo_q   <= 8'd0;
        len_q  <= 16'd0;
        idx_q  <= 16'd0;
        to_q   <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_q <= 16'd0;
`endif
      end else begin
        if (take_lo_c) lo_q <= byte_in;
        if (byte_acc_c && state_q == S_LEN_HI) len_q <= word_c;
        if (wr_c) begin
          if (idx_q != MAX_LEN) idx_q <= idx_q + 16'd1;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_q <= csum_q + word_c;
`endif
        end
        if (!in_frame_c || byte_acc_c) to_q <= '0;
        else                           to_q <= to_q + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed and randomized frames checked
// against a payload-list reference model.
module tb_uart_loader;

  localparam int unsigned TO = 100;
  localparam int unsigned MW = 1024;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic        byte_ready;
  logic [7:0]  byte_in;
  logic        clear;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic        wr_done[$];
  logic [15:0] fw[$];

  uart_loader #(.TIMEOUT_CYCLES(TO), .MAX_WORDS(MW)) dut (
    .clk_50M   (clk_50M),
    .rst       (rst),
    .byte_ready(byte_ready),
    .byte_in   (byte_in),
    .clear     (clear),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk_50M = ~clk_50M;

  // Log every memory write, sampled mid-cycle.
  always @(negedge clk_50M) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
      wr_done.push_back(done);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_50M);
    byte_in    = b;
    byte_ready = 1'b1;
    @(negedge clk_50M);
    byte_ready = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk_50M);
  endtask

  task automatic do_clear();
    @(negedge clk_50M);
    clear = 1'b1;
    @(negedge clk_50M);
    clear = 1'b0;
    tick(1);
    wr_addr.delete();
    wr_data.delete();
    wr_done.delete();
  endtask

  // Reference checksum: 16-bit modular sum of the payload words.
  function automatic logic [15:0] model_sum();
    int unsigned s = 0;
    foreach (fw[i]) s += fw[i];
    return 16'(s % 65536);
  endfunction

  task automatic send_frame();
    logic [15:0] n = 16'(fw.size());
    logic [15:0] s = model_sum();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (fw[i]) begin
      send_byte(fw[i][7:0]);
      send_byte(fw[i][15:8]);
    end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(s[7:0]);
    send_byte(s[15:8]);
`endif
  endtask

  // A well-formed frame of legal length must write every payload word in
  // order from address 0 and end in done.
  task automatic check_frame(input string tag);
    tick(2);
    check({tag, "_count"}, wr_addr.size(), fw.size());
    foreach (fw[i]) begin
      if (i < wr_addr.size()) begin
        check({tag, "_addr"}, wr_addr[i], i);
        check({tag, "_data"}, wr_data[i], fw[i]);
      end
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    byte_ready = 1'b0;
    byte_in = 8'h00;
    clear = 1'b0;
    tick(3);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 16'h0);
    check("rst_data", mem_data, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    rst = 1'b1;
    tick(3);

    // Reference frame: 0x1234, 0xABCD.
    do_clear();
    fw = '{16'h1234, 16'hABCD};
    send_frame();
    check_frame("ref");
    if (wr_done.size() == 2) begin
      check("ref_done_w0", wr_done[0], 1'b0);
`ifdef UART_LOADER_CHECKSUM_EN
      check("ref_done_w1", wr_done[1], 1'b0);
`else
      check("ref_done_w1", wr_done[1], 1'b1);
`endif
    end

    // Bytes after done are ignored.
    send_byte(8'h01);
    send_byte(8'h00);
    tick(2);
    check("done_ignore_busy", busy, 1'b0);
    check("done_ignore_done", done, 1'b1);
    do_clear();
    check("clear_done", done, 1'b0);

    // Randomized frames.
    for (int r = 0; r < 5; r++) begin
      do_clear();
      fw.delete();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) fw.push_back(16'($urandom));
      send_frame();
      check_frame("rand");
    end

    // Zero-length frame.
    do_clear();
    fw.delete();
    send_frame();
    check_frame("len0");

    // Largest legal length.
    do_clear();
    fw.delete();
    for (int k = 0; k < int'(MW); k++) fw.push_back(16'($urandom));
    send_frame();
    check_frame("maxlen");

    // Oversize length 0x0401.
    do_clear();
    send_byte(8'h01);
    send_byte(8'h04);
    tick(1);
    check("over_error", error, 1'b1);
    check("over_done", done, 1'b0);
    check("over_busy", busy, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    tick(2);
    check("over_nowrite", wr_addr.size(), 0);

`ifdef UART_LOADER_CHECKSUM_EN
    // Wrong checksum: 0x0006 against actual sum 0x0005.
    do_clear();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h06); send_byte(8'h00);
    tick(2);
    check("csum_error", error, 1'b1);
    check("csum_done", done, 1'b0);
    check("csum_count", wr_addr.size(), 1);
    if (wr_addr.size() == 1) check("csum_data", wr_data[0], 16'h0005);
`endif

    // Timeout: error exactly TO cycles after the last accepted byte.
    do_clear();
    send_byte(8'h03);
    send_byte(8'h00);
    @(negedge clk_50M);
    byte_in = 8'h11;
    byte_ready = 1'b1;
    @(posedge clk_50M);
    #1 byte_ready = 1'b0;
    for (int j = 1; j <= int'(TO); j++) begin
      @(posedge clk_50M);
      #1;
      if (j == int'(TO) - 1) begin
        check("to_early_error", error, 1'b0);
        check("to_early_busy", busy, 1'b1);
      end
      if (j == int'(TO)) begin
        check("to_error", error, 1'b1);
        check("to_busy", busy, 1'b0);
      end
    end
    check("to_nowrite", wr_addr.size(), 0);

    // Held-high byte_ready counts once; LEN must come out as 2.
    do_clear();
    @(negedge clk_50M);
    byte_in = 8'h02;
    byte_ready = 1'b1;
    tick(50);
    byte_ready = 1'b0;
    tick(1);
    check("hold_busy", busy, 1'b1);
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    tick(2);
    check("hold_count", wr_addr.size(), 1);
    if (wr_addr.size() == 1) check("hold_data", wr_data[0], 16'h1234);
    check("hold_mid_busy", busy, 1'b1);
    // Clear coincident with the DATA_HI byte edge drops the byte.
    send_byte(8'hCD);
    @(negedge clk_50M);
    byte_in = 8'hAB;
    byte_ready = 1'b1;
    clear = 1'b1;
    @(negedge clk_50M);
    clear = 1'b0;
    byte_ready = 1'b0;
    tick(2);
    check("clr_count", wr_addr.size(), 1);
    check("clr_done", done, 1'b0);
    check("clr_error", error, 1'b0);
    check("clr_busy", busy, 1'b0);
    wr_addr.delete(); wr_data.delete(); wr_done.delete();
    fw = '{16'h6677};
    send_frame();
    check_frame("after_clr");

    // Reset mid-frame, with byte_ready high across reset release.
    do_clear();
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h00);
    send_byte(8'h22); send_byte(8'h00);
    tick(1);
    check("pre_rst_writes", wr_addr.size(), 2);
    @(negedge clk_50M);
    byte_in = 8'h07;
    byte_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_addr", mem_addr, 16'h0);
    check("arst_data", mem_data, 16'h0);
    tick(2);
    rst = 1'b1;
    tick(5);
    check("rst_held_busy", busy, 1'b0);
    byte_ready = 1'b0;
    tick(2);
    check("rst_fall_busy", busy, 1'b0);
    wr_addr.delete(); wr_data.delete(); wr_done.delete();
    fw = '{16'($urandom), 16'($urandom)};
    send_frame();
    check_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
